// File: rtl/gf7_pkg.sv
// gf7_pkg: shared constants and FSM state type for the GF(2^7) exponentiator.
// Field is GF(2^7), reduced by x^7 + x + 1.
package gf7_pkg;

  localparam int         GF_M        = 7;
  localparam logic [6:0] GF_POLY_LOW = 7'h03;
  localparam logic [6:0] GF_ONE      = 7'h01;
  localparam logic [6:0] GF_INV_EXP  = 7'd126;

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    MUL,
    DONE
  } state_e;

endpackage

// File: rtl/gf7_mul.sv
// gf7_mul: combinational GF(2^7) multiplier.
// Carry-less 7x7 product, then fold high terms using x^7 = x + 1.
module gf7_mul
  import gf7_pkg::*;
(
  input  logic [GF_M-1:0] a_i,
  input  logic [GF_M-1:0] b_i,
  output logic [GF_M-1:0] p_o
);

  logic [2*GF_M-2:0] full;

  // Shift-and-xor product, then reduce from the top term down
  always_comb begin
    full = '0;
    for (int i = 0; i < GF_M; i++) begin
      if (b_i[i]) begin
        full = full ^ ({{(GF_M-1){1'b0}}, a_i} << i);
      end
    end
    for (int i = 2*GF_M-2; i >= GF_M; i--) begin
      if (full[i]) begin
        full = full ^ ({{(GF_M-2){1'b0}}, 1'b1, GF_POLY_LOW} << (i - GF_M));
      end
    end
    p_o = full[GF_M-1:0];
  end

endmodule

// File: rtl/gf7_pow.sv
// gf7_pow: base^exp over GF(2^7), left-to-right square-and-multiply.
// Define GF7_POW_INV_EN to add the inv port (forces exponent 126).
module gf7_pow
  import gf7_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] base,
  input  logic [6:0] exp,
`ifdef GF7_POW_INV_EN
  input  logic       inv,
`endif
  output logic       busy,
  output logic       done,
  output logic [6:0] result
);

  state_e     state_q, state_d;
  logic [6:0] acc_q, acc_d;
  logic [6:0] base_q, base_d;
  logic [6:0] exp_q, exp_d;
  logic [6:0] res_q, res_d;
  logic [2:0] idx_q, idx_d;
  logic [6:0] mul_b;
  logic [6:0] prod;
  logic [6:0] exp_sel;

`ifdef GF7_POW_INV_EN
  assign exp_sel = inv ? GF_INV_EXP : exp;
`else
  assign exp_sel = exp;
`endif

  // Operand mux: square in SQR, multiply by base in MUL
  assign mul_b = (state_q == MUL) ? base_q : acc_q;

  gf7_mul u_mul (
    .a_i (acc_q),
    .b_i (mul_b),
    .p_o (prod)
  );

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    exp_d   = exp_q;
    res_d   = res_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SQR;
          base_d  = base;
          exp_d   = exp_sel;
          acc_d   = GF_ONE;
          idx_d   = 3'd6;
        end else begin
          state_d = IDLE;
        end
      end
      SQR: begin
        acc_d   = prod;
        state_d = MUL;
      end
      MUL: begin
        if (exp_q[idx_q]) begin
          acc_d = prod;
        end
        if (idx_q == 3'd0) begin
          state_d = DONE;
          res_d   = exp_q[idx_q] ? prod : acc_q;
        end else begin
          idx_d   = idx_q - 3'd1;
          state_d = SQR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      res_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
    end
  end

  assign busy   = (state_q == SQR) || (state_q == MUL);
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule
